gpioemu_host: RTL and testbench
===============================

Name: gpioemu_host

Overview:
- Bus-initiator engine that drives the gpioemu register interface: saddress, srd and swr strobes, and the data buses.
- Accepts a multiply command (A1, A2) on a valid/ready port.
- Writes the operands, starts the operation, polls the status register, then reads back the product (W) and the ones-count (L).
- Returns the result on a valid/ready response port. Sits between on-chip control logic and the emulated peripheral.

Parameters:
- STROBE_CYCLES, 2, clocks srd/swr held high per access (legal range 1..15)
- POLL_GAP, 4, idle clocks between consecutive status polls (0..255)
- POLL_LIMIT, 1024, polls before timeout (used only with GPIOEMU_HOST_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when the engine is idle and can accept a command
- cmd_a1  in  24  operand A1
- cmd_a2  in  24  operand A2
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_w  out  32  product low word, read from 0x0390
- res_l  out  24  ones-count, read from 0x0398
- res_ovf  out  1  product exceeded 32 bits (inverse of status bit0)
- res_timeout  out  1  poll timed out (constant 0 without the feature)
- saddress  out  16  peripheral register address
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_out  out  32  write data, connects to peripheral sdata_in
- sdata_in  in  32  read data, connects to peripheral sdata_out

Behaviour:
- Reset values (synchronous, evaluated on clk rising edge):
  - srd=0, swr=0, saddress=0, sdata_out=0
  - cmd_ready=1, res_valid=0, res_w=0, res_l=0, res_ovf=0, res_timeout=0
  - state=IDLE, all counters 0
- Reset during an operation: the strobes drop on the reset edge and the transaction is abandoned; no response is produced.
- Register map (fixed):
  - 0x0380 A1 (write)
  - 0x0388 A2 (write)
  - 0x03A0 start on write / status on read, status = {ready, valid} in bits [1:0]
  - 0x0390 W (read)
  - 0x0398 L (read)
- Bus access micro-sequence, used for every access:
  - SETUP (1 clk): saddress and sdata_out driven, strobes low.
  - STROBE (STROBE_CYCLES clks): the chosen strobe is high; address and data held.
  - HOLD (1 clk): strobe low, address held. Read data is sampled from sdata_in in this cycle.
  - Each access therefore takes STROBE_CYCLES+2 clocks. srd and swr are never high together. Address and data never change while a strobe is high.
- Command handshake:
  - A command is accepted on the clk edge where cmd_valid && cmd_ready.
  - The operands are captured then; cmd_ready drops the same edge and stays low until the response is accepted.
  - The SETUP of the first access is the next clock.
- Main FSM, linear order:
  - IDLE -> WR_A1: write cmd_a1 zero-extended to 32 bits at 0x0380.
  - WR_A1 -> WR_A2: write cmd_a2 zero-extended at 0x0388.
  - WR_A2 -> WR_GO: write 0 at 0x03A0.
  - WR_GO -> POLL: read 0x03A0.
    - If bit1=1, go to RD_W.
    - Otherwise wait POLL_GAP clocks, then POLL again.
    - The first poll follows WR_GO with no gap.
  - RD_W: read 0x0390 into res_w.
  - RD_L: read 0x0398; res_l = sdata_in[23:0].
  - RESP: res_valid=1. res_ovf = ~bit0 of the last status poll.
  - RESP -> IDLE on the edge where res_valid && res_ready. res_valid drops and cmd_ready rises on that edge.
- Result outputs are stable while res_valid=1. res_ready asserted when res_valid=0 is ignored.
- Minimum command-to-res_valid latency with STROBE_CYCLES=2 and the first poll done is 6 accesses x 4 clks + 1 = 25 clocks after acceptance.
- The poll counter saturates; it does not wrap.

Optional Feature:
- Macro: GPIOEMU_HOST_TIMEOUT_EN.
- When defined:
  - A 16-bit counter counts completed polls with bit1=0.
  - When it reaches POLL_LIMIT, the FSM skips RD_W and RD_L and goes to RESP with res_timeout=1, res_w=0, res_l=0, res_ovf=0.
  - The counter clears on command accept.
- When not defined: there is no counter, polling continues indefinitely, and res_timeout is tied to 0.

Test Plan:
- Reset asserted for 2 clks mid-STROBE of WR_A2 -> swr=0 on the reset edge, cmd_ready=1 and res_valid=0 after release, no further bus activity.
- Command A1=3, A2=5; responder model reports status 2'b11 on the first poll, W=15, L=4 -> bus trace writes 0x3/0x380, 0x5/0x388, 0x0/0x3A0 in order, each access exactly 4 clks; res_valid at clock 25 with res_w=15, res_l=4, res_ovf=0.
- Model returns status 2'b01 on three polls, then 2'b11 -> exactly four srd pulses at 0x03A0, spaced 4+POLL_GAP clks apart; then reads of 0x0390 and 0x0398.
- Model returns status 2'b10, W=0xFE000001, L=8 -> res_ovf=1, res_w=0xFE000001, res_l=8.
- res_ready held low for 10 clks after res_valid -> outputs stable, cmd_ready=0, a new cmd_valid is not accepted; accepted on the clock after the response handshake completes.
- GPIOEMU_HOST_TIMEOUT_EN with POLL_LIMIT=3; model always returns status 2'b01 -> exactly 3 polls, no reads of 0x0390 or 0x0398, res_timeout=1, res_w=0, res_l=0.

Source files
------------

// File: rtl/gpioemu_host.sv
// gpioemu_host: bus initiator that runs one A1*A2 multiply on the gpioemu peripheral and returns W and L.
// Define GPIOEMU_HOST_TIMEOUT_EN to bound status polling at POLL_LIMIT busy polls.
module gpioemu_host #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_GAP      = 4,
  parameter int POLL_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [23:0] res_l,
  output logic        res_ovf,
  output logic        res_timeout,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam logic [15:0] ADDR_A1  = 16'h0380;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_L   = 16'h0398;
  localparam logic [15:0] ADDR_CTL = 16'h03A0;
  localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_GAP, S_RD_W, S_RD_L, S_RESP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [3:0]  strobe_cnt_q, strobe_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [23:0] a1_q, a1_d, a2_q, a2_d;
  logic [31:0] res_w_q, res_w_d;
  logic [23:0] res_l_q, res_l_d;
  logic        res_ovf_q, res_ovf_d;

  logic in_access, hold, cmd_fire, poll_busy, timeout_hit, is_read;

  assign in_access = (state_q == S_WR_A1) || (state_q == S_WR_A2) || (state_q == S_WR_GO) ||
                     (state_q == S_POLL)  || (state_q == S_RD_W)  || (state_q == S_RD_L);
  assign hold      = in_access && (phase_q == PH_HOLD);
  assign cmd_fire  = cmd_valid && (state_q == S_IDLE);
  assign poll_busy = hold && (state_q == S_POLL) && !sdata_in[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_SETUP;
      strobe_cnt_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      strobe_cnt_q <= strobe_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    strobe_cnt_d = strobe_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    // Every access walks SETUP -> STROBE -> HOLD and returns to SETUP for the next one.
    if (in_access) begin
      case (phase_q)
        PH_SETUP: begin
          phase_d      = PH_STROBE;
          strobe_cnt_d = STROBE_LAST;
        end
        PH_STROBE: begin
          if (strobe_cnt_q == 4'd0) phase_d = PH_HOLD;
          else strobe_cnt_d = strobe_cnt_q - 4'd1;
        end
        default: phase_d = PH_SETUP;
      endcase
    end

    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_WR_A1;
      S_WR_A1: if (hold) state_d = S_WR_A2;
      S_WR_A2: if (hold) state_d = S_WR_GO;
      S_WR_GO: if (hold) state_d = S_POLL;
      S_POLL: begin
        if (hold) begin
          if (sdata_in[1]) begin
            state_d = S_RD_W;
          end else if (timeout_hit) begin
            state_d = S_RESP;
          end else if (POLL_GAP == 0) begin
            state_d = S_POLL;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = S_POLL;
        else gap_cnt_d = gap_cnt_q - 8'd1;
      end
      S_RD_W:  if (hold) state_d = S_RD_L;
      S_RD_L:  if (hold) state_d = S_RESP;
      S_RESP:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    saddress  = 16'h0000;
    sdata_out = 32'h0000_0000;
    is_read   = 1'b0;
    case (state_q)
      S_WR_A1: begin
        saddress  = ADDR_A1;
        sdata_out = {8'h00, a1_q};
      end
      S_WR_A2: begin
        saddress  = ADDR_A2;
        sdata_out = {8'h00, a2_q};
      end
      S_WR_GO: saddress = ADDR_CTL;
      S_POLL: begin
        saddress = ADDR_CTL;
        is_read  = 1'b1;
      end
      S_RD_W: begin
        saddress = ADDR_W;
        is_read  = 1'b1;
      end
      S_RD_L: begin
        saddress = ADDR_L;
        is_read  = 1'b1;
      end
      default: ;
    endcase
    srd       = in_access && is_read && (phase_q == PH_STROBE);
    swr       = in_access && !is_read && (phase_q == PH_STROBE);
    cmd_ready = (state_q == S_IDLE);
    res_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_q      <= '0;
      a2_q      <= '0;
      res_w_q   <= '0;
      res_l_q   <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      res_w_q   <= res_w_d;
      res_l_q   <= res_l_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  always_comb begin
    a1_d      = a1_q;
    a2_d      = a2_q;
    res_w_d   = res_w_q;
    res_l_d   = res_l_q;
    res_ovf_d = res_ovf_q;
    if (cmd_fire) begin
      a1_d = cmd_a1;
      a2_d = cmd_a2;
    end
    if (hold) begin
      case (state_q)
        S_POLL: begin
          res_ovf_d = ~sdata_in[0];
          // A timed-out command reports an all-zero result rather than stale data.
          if (poll_busy && timeout_hit) begin
            res_w_d   = '0;
            res_l_d   = '0;
            res_ovf_d = 1'b0;
          end
        end
        S_RD_W:  res_w_d = sdata_in;
        S_RD_L:  res_l_d = sdata_in[23:0];
        default: ;
      endcase
    end
  end

  assign res_w   = res_w_q;
  assign res_l   = res_l_q;
  assign res_ovf = res_ovf_q;

`ifdef GPIOEMU_HOST_TIMEOUT_EN
  localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

  logic [15:0] poll_cnt_q, poll_cnt_d, poll_cnt_inc;
  logic        res_timeout_q, res_timeout_d;

  assign poll_cnt_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign timeout_hit  = (poll_cnt_inc >= POLL_LIMIT_W);

  always_comb begin
    poll_cnt_d    = poll_cnt_q;
    res_timeout_d = res_timeout_q;
    if (cmd_fire) begin
      poll_cnt_d    = '0;
      res_timeout_d = 1'b0;
    end else if (poll_busy) begin
      poll_cnt_d = poll_cnt_inc;
      if (timeout_hit) res_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      poll_cnt_q    <= poll_cnt_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign res_timeout = res_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpioemu_host.sv
// Scoreboard bench for gpioemu_host: a peripheral model answers reads, a monitor checks every bus access and response.
module tb_gpioemu_host;

  localparam int SC = 2;
  localparam int PG = 4;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
  localparam int PL    = 3;
  localparam int NBUSY = 2;
`else
  localparam int PL    = 1024;
  localparam int NBUSY = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [23:0] cmd_a1 = '0, cmd_a2 = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [31:0] res_w;
  logic [23:0] res_l;
  logic        res_ovf, res_timeout;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_out, sdata_in;

  gpioemu_host #(.STROBE_CYCLES(SC), .POLL_GAP(PG), .POLL_LIMIT(PL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_l(res_l),
    .res_ovf(res_ovf), .res_timeout(res_timeout),
    .saddress(saddress), .srd(srd), .swr(swr), .sdata_out(sdata_out), .sdata_in(sdata_in)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [15:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [31:0] w; logic [23:0] l; logic ovf; logic to; } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model configuration for the current command
  int          m_nb = 0;
  logic [1:0]  m_bst = 2'b01, m_dst = 2'b11;
  logic [31:0] m_w = '0;
  logic [23:0] m_l = '0;
  logic [1:0]  cur_st = 2'b00;

  assign sdata_in = (saddress == 16'h03A0) ? {30'h0, cur_st} :
                    (saddress == 16'h0390) ? m_w :
                    (saddress == 16'h0398) ? {8'hA5, m_l} : 32'hDEAD_BEEF;

  int          cyc = 0, n_strobes = 0, n_polls = 0, polls_seen = 0;
  int          last_start = -1, last_poll = -1, stb_len = 0;
  logic        stb_prev = 1'b0, last_was_poll = 1'b0;
  logic [15:0] prev_addr = '0, stb_addr = '0;
  logic [31:0] stb_data = '0;

  always @(negedge clk) begin
    bus_t e;
    res_t r;
    logic stb;
    cyc++;
    stb = srd | swr;
    if (stb && !stb_prev) begin
      n_strobes++;
      stb_addr = saddress;
      stb_data = sdata_out;
      stb_len  = 0;
      check("strobe_excl", srd & swr, 1'b0);
      check("setup_addr", prev_addr, saddress);
      if (!(swr && saddress == 16'h0380) && last_start >= 0)
        check("access_spacing", cyc - last_start,
              (srd && saddress == 16'h03A0 && last_was_poll) ? SC + 2 + PG : SC + 2);
      last_start = cyc;
      last_was_poll = srd && (saddress == 16'h03A0);
      check("bus_q_nonempty", exp_bus.size() > 0, 1'b1);
      if (exp_bus.size() > 0) begin
        e = exp_bus.pop_front();
        check("bus_kind", swr, e.wr);
        check("bus_addr", saddress, e.addr);
        if (e.wr) check("bus_data", sdata_out, e.data);
      end
      if (swr && saddress == 16'h03A0) begin
        polls_seen = 0;
        last_poll  = -1;
      end
      if (srd && saddress == 16'h03A0) begin
        if (last_poll >= 0) check("poll_spacing", cyc - last_poll, SC + 2 + PG);
        last_poll  = cyc;
        cur_st     = (polls_seen < m_nb) ? m_bst : m_dst;
        polls_seen++;
        n_polls++;
      end
    end
    if (stb) begin
      stb_len++;
      if (stb_len > 1) check("stb_hold", {saddress, sdata_out}, {stb_addr, stb_data});
    end
    if (!stb && stb_prev && !reset) check("stb_len", stb_len, SC);
    if (res_valid && res_ready && !reset) begin
      check("res_q_nonempty", exp_res.size() > 0, 1'b1);
      if (exp_res.size() > 0) begin
        r = exp_res.pop_front();
        check("res_w", res_w, r.w);
        check("res_l", res_l, r.l);
        check("res_ovf", res_ovf, r.ovf);
        check("res_timeout", res_timeout, r.to);
      end
    end
    stb_prev  = stb;
    prev_addr = saddress;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [23:0] a1, input logic [23:0] a2, input int nb,
                          input logic [1:0] bst, input logic [1:0] dst,
                          input logic [31:0] w, input logic [23:0] l);
    logic to;
    int   np;
    res_t r;
    m_nb = nb; m_bst = bst; m_dst = dst; m_w = w; m_l = l;
    to = 1'b0;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
    to = (nb >= PL);
`endif
    np = to ? PL : nb + 1;
    exp_bus.push_back('{1'b1, 16'h0380, {8'h00, a1}});
    exp_bus.push_back('{1'b1, 16'h0388, {8'h00, a2}});
    exp_bus.push_back('{1'b1, 16'h03A0, 32'h0});
    for (int i = 0; i < np; i++) exp_bus.push_back('{1'b0, 16'h03A0, 32'h0});
    if (!to) begin
      exp_bus.push_back('{1'b0, 16'h0390, 32'h0});
      exp_bus.push_back('{1'b0, 16'h0398, 32'h0});
    end
    r.w = to ? 32'h0 : w;
    r.l = to ? 24'h0 : l;
    r.ovf = to ? 1'b0 : ~dst[0];
    r.to = to;
    exp_res.push_back(r);
    cmd_a1 = a1;
    cmd_a2 = a2;
  endtask

  task automatic send_cmd();
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // lat counts clocks after the accept edge; clock 1 is the first SETUP cycle
  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 3000) begin
      tick();
      lat++;
    end
    check("res_valid_wait", res_valid, 1'b1);
  endtask

  task automatic complete_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_res_valid", res_valid, 1'b0);
    check("hs_cmd_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int p0, s0;

    tick();
    tick();
    reset = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_strobes", {srd, swr}, 2'b00);
    check("rst_saddress", saddress, 16'h0);
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_results", {res_w, res_l, res_ovf, res_timeout}, 58'h0);
    tick();

    // 3 * 5, ready on the first poll
    push_cmd(24'd3, 24'd5, 0, 2'b01, 2'b11, 32'd15, 24'd4);
    send_cmd();
    wait_res(lat);
    check("latency", lat, 25);
    complete_res();
    tick();

    // Busy polls before ready
    p0 = n_polls;
    push_cmd(24'h000100, 24'h000200, NBUSY, 2'b01, 2'b11, 32'h0002_0000, 24'd1);
    send_cmd();
    wait_res(lat);
    check("poll_count", n_polls - p0, NBUSY + 1);
    complete_res();
    tick();

    // Product overflow
    push_cmd(24'hFFFFFF, 24'hFFFFFF, 0, 2'b01, 2'b10, 32'hFE00_0001, 24'd8);
    send_cmd();
    wait_res(lat);
    complete_res();
    tick();

    // Response stall with a queued command
    push_cmd(24'd7, 24'd9, 0, 2'b01, 2'b11, 32'd63, 24'd6);
    send_cmd();
    wait_res(lat);
    s0 = n_strobes;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_res_valid", res_valid, 1'b1);
      check("stall_res_w", res_w, 32'd63);
      check("stall_res_l", res_l, 24'd6);
      check("stall_cmd_ready", cmd_ready, 1'b0);
      if (i == 5) push_cmd(24'd2, 24'd4, 0, 2'b01, 2'b11, 32'd8, 24'd1);
    end
    check("stall_no_bus", n_strobes, s0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("stall_hs_cmd_ready", cmd_ready, 1'b1);
    tick();
    check("stall_accept", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    wait_res(lat);
    complete_res();
    tick();

`ifdef GPIOEMU_HOST_TIMEOUT_EN
    p0 = n_polls;
    push_cmd(24'd11, 24'd13, 100, 2'b01, 2'b11, 32'd143, 24'd3);
    send_cmd();
    wait_res(lat);
    check("timeout_polls", n_polls - p0, PL);
    complete_res();
    tick();
`endif

    check("bus_q_drained", exp_bus.size(), 0);
    check("res_q_drained", exp_res.size(), 0);

    // Reset in the middle of the A2 write strobe
    push_cmd(24'd21, 24'd22, 0, 2'b01, 2'b11, 32'd462, 24'd5);
    send_cmd();
    for (int i = 0; i < 40 && !(swr && saddress == 16'h0388); i++) tick();
    check("wr_a2_strobe", {swr, saddress}, {1'b1, 16'h0388});
    reset = 1'b1;
    tick();
    check("rst_edge_swr", swr, 1'b0);
    tick();
    reset = 1'b0;
    exp_bus.delete();
    exp_res.delete();
    check("rst2_cmd_ready", cmd_ready, 1'b1);
    check("rst2_res_valid", res_valid, 1'b0);
    s0 = n_strobes;
    for (int i = 0; i < 30; i++) tick();
    check("rst2_no_bus", n_strobes, s0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
